// File: rtl/cmsdk_my_input_stage_m0_if.sv
// Signal bundle for one AHB bus-matrix input-stage port.
// The slave modport is the input stage. The master modport is the upstream master, arbiter and output stage.
interface cmsdk_my_input_stage_m0_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  HSELS;
   logic [ADDR_WIDTH-1:0] HADDRS;
   logic [1:0]            HTRANSS;
   logic                  HWRITES;
   logic [2:0]            HSIZES;
   logic [2:0]            HBURSTS;
   logic [3:0]            HPROTS;
   logic                  HMASTLOCKS;
   logic                  HREADYS;
   logic                  addr_grant;
   logic                  HREADYM;
   logic                  HREADYOUTM;
   logic                  HRESPM;
   logic                  HREADYOUTS;
   logic                  HRESPS;
   logic                  req_port;
   logic                  HSELI;
   logic [ADDR_WIDTH-1:0] HADDRI;
   logic [1:0]            HTRANSI;
   logic                  HWRITEI;
   logic [2:0]            HSIZEI;
   logic [2:0]            HBURSTI;
   logic [3:0]            HPROTI;
   logic                  HMASTLOCKI;

   modport slave (
      input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS,
      input  HREADYS, addr_grant, HREADYM, HREADYOUTM, HRESPM,
      output HREADYOUTS, HRESPS, req_port,
      output HSELI, HADDRI, HTRANSI, HWRITEI, HSIZEI, HBURSTI, HPROTI, HMASTLOCKI
   );

   modport master (
      output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS,
      output HREADYS, addr_grant, HREADYM, HREADYOUTM, HRESPM,
      input  HREADYOUTS, HRESPS, req_port,
      input  HSELI, HADDRI, HTRANSI, HWRITEI, HSIZEI, HBURSTI, HPROTI, HMASTLOCKI
   );
endinterface

// File: rtl/cmsdk_my_input_stage_m0.sv
// AHB bus-matrix input stage. It holds an ungranted address phase and wait-states the master until the arbiter accepts it.
// Optional macro INSTAGE_BURST_OVERRIDE_EN: a held SEQ beat and the rest of its burst are re-presented as NONSEQ/INCR.
module cmsdk_my_input_stage_m0 #(
   parameter int ADDR_WIDTH = 32
) (
   input logic                     HCLK,
   input logic                     HRESET,
   cmsdk_my_input_stage_m0_if.slave bus
);
   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;
   localparam logic [2:0] BU_INCR   = 3'b001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PEND = 2'b01,
      ST_DATA = 2'b10
   } state_t;

   state_t                state, state_nxt;
   logic                  live_valid, accept, sample, capture;
   logic [ADDR_WIDTH-1:0] held_addr;
   logic [1:0]            held_trans;
   logic                  held_write;
   logic [2:0]            held_size;
   logic [2:0]            held_burst;
   logic [3:0]            held_prot;
   logic                  held_lock;

   // The request and live outputs are gated by reset so that they sit at reset values while HRESET is high.
   assign live_valid = bus.HSELS & bus.HREADYS & bus.HTRANSS[1] & ~HRESET;
   assign accept     = bus.addr_grant & bus.HREADYM;
   assign sample     = (state == ST_IDLE) | ((state == ST_DATA) & bus.HREADYOUTM);
   assign capture    = sample & live_valid & ~accept;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_PEND: if (accept) state_nxt = ST_DATA;
         ST_IDLE, ST_DATA: begin
            if (sample) begin
               if (live_valid) state_nxt = accept ? ST_DATA : ST_PEND;
               else            state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state      <= ST_IDLE;
         held_addr  <= '0;
         held_trans <= '0;
         held_write <= 1'b0;
         held_size  <= '0;
         held_burst <= '0;
         held_prot  <= '0;
         held_lock  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            held_addr  <= bus.HADDRS;
            held_trans <= bus.HTRANSS;
            held_write <= bus.HWRITES;
            held_size  <= bus.HSIZES;
            held_burst <= bus.HBURSTS;
            held_prot  <= bus.HPROTS;
            held_lock  <= bus.HMASTLOCKS;
         end
      end
   end

`ifdef INSTAGE_BURST_OVERRIDE_EN
   // A held SEQ beat marks the rest of its burst. The mark clears at the next live NONSEQ.
   logic burst_ovr;
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET)
         burst_ovr <= 1'b0;
      else if (sample & live_valid)
         burst_ovr <= (bus.HTRANSS == TR_SEQ) & (capture | burst_ovr);
   end
`endif

   always_comb begin
      bus.req_port   = (state == ST_PEND) | live_valid;
      bus.HSELI      = bus.HSELS & ~HRESET;
      bus.HADDRI     = bus.HADDRS;
      bus.HTRANSI    = (bus.HSELS & bus.HREADYS & ~HRESET) ? bus.HTRANSS : TR_IDLE;
      bus.HWRITEI    = bus.HWRITES;
      bus.HSIZEI     = bus.HSIZES;
      bus.HBURSTI    = bus.HBURSTS;
      bus.HPROTI     = bus.HPROTS;
      bus.HMASTLOCKI = bus.HMASTLOCKS;
      bus.HREADYOUTS = 1'b1;
      bus.HRESPS     = 1'b0;
      case (state)
         ST_PEND: begin
            bus.HSELI      = 1'b1;
            bus.HADDRI     = held_addr;
            bus.HTRANSI    = held_trans;
            bus.HWRITEI    = held_write;
            bus.HSIZEI     = held_size;
            bus.HBURSTI    = held_burst;
            bus.HPROTI     = held_prot;
            bus.HMASTLOCKI = held_lock;
            bus.HREADYOUTS = 1'b0;
`ifdef INSTAGE_BURST_OVERRIDE_EN
            if (held_trans == TR_SEQ) begin
               bus.HTRANSI = TR_NONSEQ;
               bus.HBURSTI = BU_INCR;
            end
`endif
         end
         ST_DATA: begin
            bus.HREADYOUTS = bus.HREADYOUTM;
            bus.HRESPS     = bus.HRESPM;
         end
         default: ;
      endcase
`ifdef INSTAGE_BURST_OVERRIDE_EN
      if ((state != ST_PEND) && burst_ovr && (bus.HTRANSI == TR_SEQ)) begin
         bus.HTRANSI = TR_NONSEQ;
         bus.HBURSTI = BU_INCR;
      end
`endif
   end
endmodule

// File: tb/tb_cmsdk_my_input_stage_m0.sv
// Directed bench for cmsdk_my_input_stage_m0. It covers reset, granted, held and stalled transfers, the error response and a reset pulse while a transfer is held.
module tb_cmsdk_my_input_stage_m0;
   logic HCLK = 1'b0;
   logic HRESET = 1'b1;
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   cmsdk_my_input_stage_m0_if #(.ADDR_WIDTH(32)) bus ();

   cmsdk_my_input_stage_m0 #(.ADDR_WIDTH(32)) dut (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (bus)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Inputs are driven 1 time unit after the rising edge. Outputs are checked 1 time unit later.
   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle_bus();
      bus.HSELS = 1'b0; bus.HADDRS = '0; bus.HTRANSS = 2'b00; bus.HWRITES = 1'b0;
      bus.HSIZES = 3'b010; bus.HBURSTS = 3'b000; bus.HPROTS = 4'h3; bus.HMASTLOCKS = 1'b0;
   endtask

   task automatic drive(input logic [31:0] a, input logic [1:0] tr, input logic wr,
                        input logic [2:0] bu, input logic lk);
      bus.HSELS = 1'b1; bus.HADDRS = a; bus.HTRANSS = tr; bus.HWRITES = wr;
      bus.HBURSTS = bu; bus.HMASTLOCKS = lk; bus.HPROTS = 4'hA; bus.HSIZES = 3'b010;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset with an active-looking master request that must stay masked.
      drive(32'h1111_0000, 2'b10, 1'b1, 3'b000, 1'b0);
      bus.HREADYS = 1'b1; bus.addr_grant = 1'b0; bus.HREADYM = 1'b1;
      bus.HREADYOUTM = 1'b1; bus.HRESPM = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("rst_rdy",   {31'b0, bus.HREADYOUTS}, 32'd1);
         chk("rst_resp",  {31'b0, bus.HRESPS},     32'd0);
         chk("rst_req",   {31'b0, bus.req_port},   32'd0);
         chk("rst_trans", {30'b0, bus.HTRANSI},    32'd0);
         chk("rst_sel",   {31'b0, bus.HSELI},      32'd0);
         @(posedge HCLK);
      end
      #1; HRESET = 1'b0; idle_bus();

      // 2: granted NONSEQ write, slave inserts one wait state.
      tick();
      drive(32'h2000_0000, 2'b10, 1'b1, 3'b000, 1'b0);
      bus.addr_grant = 1'b1;
      #1;
      chk("wr_req",   {31'b0, bus.req_port},   32'd1);
      chk("wr_addr",  bus.HADDRI,              32'h2000_0000);
      chk("wr_trans", {30'b0, bus.HTRANSI},    32'd2);
      chk("wr_rdy0",  {31'b0, bus.HREADYOUTS}, 32'd1);
      tick(); idle_bus(); bus.HREADYOUTM = 1'b0;
      #1;
      chk("wr_wait",  {31'b0, bus.HREADYOUTS}, 32'd0);
      chk("wr_req_d", {31'b0, bus.req_port},   32'd0);
      tick(); bus.HREADYOUTM = 1'b1;
      #1;
      chk("wr_done",  {31'b0, bus.HREADYOUTS}, 32'd1);
      tick();

      // 3: ungranted NONSEQ read is held for three cycles while the master address toggles.
      drive(32'h4000_0010, 2'b10, 1'b0, 3'b000, 1'b0);
      bus.addr_grant = 1'b0;
      #1;
      chk("rd_req0", {31'b0, bus.req_port}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         bus.HADDRS = 32'hFFFF_0000 ^ i; bus.HTRANSS = 2'(i); bus.HWRITES = 1'b1;
         #1;
         chk("rd_pend_rdy",  {31'b0, bus.HREADYOUTS}, 32'd0);
         chk("rd_pend_req",  {31'b0, bus.req_port},   32'd1);
         chk("rd_pend_addr", bus.HADDRI,              32'h4000_0010);
         chk("rd_pend_tr",   {30'b0, bus.HTRANSI},    32'd2);
         chk("rd_pend_wr",   {31'b0, bus.HWRITEI},    32'd0);
         chk("rd_pend_sel",  {31'b0, bus.HSELI},      32'd1);
      end
      idle_bus(); bus.addr_grant = 1'b1;
      tick();
      #1;
      chk("rd_data_rdy", {31'b0, bus.HREADYOUTS}, 32'd1);
      chk("rd_data_req", {31'b0, bus.req_port},   32'd0);
      bus.addr_grant = 1'b0;
      tick();

      // 4: grant without HREADYM is not an accept. The locked transfer stays held.
      drive(32'h6000_0000, 2'b10, 1'b0, 3'b000, 1'b1);
      tick();
      idle_bus(); bus.addr_grant = 1'b1; bus.HREADYM = 1'b0;
      #1;
      chk("hm0_rdy", {31'b0, bus.HREADYOUTS}, 32'd0);
      tick();
      #1;
      chk("hm0_stay_rdy", {31'b0, bus.HREADYOUTS}, 32'd0);
      chk("hm0_stay_req", {31'b0, bus.req_port},   32'd1);
      chk("hm0_addr",     bus.HADDRI,              32'h6000_0000);
      chk("hm0_lock",     {31'b0, bus.HMASTLOCKI}, 32'd1);
      chk("hm0_prot",     {28'b0, bus.HPROTI},     32'hA);
      bus.HREADYM = 1'b1;
      tick();
      bus.HRESPM = 1'b1;
      #1;
      chk("hm1_rdy",  {31'b0, bus.HREADYOUTS}, 32'd1);
      chk("hm1_resp", {31'b0, bus.HRESPS},     32'd1);
      bus.HRESPM = 1'b0;
      tick();

      // 5: two-cycle ERROR response. A BUSY beat in the second cycle is not captured.
      drive(32'h5000_0000, 2'b10, 1'b1, 3'b000, 1'b0);
      tick();
      idle_bus(); bus.addr_grant = 1'b0; bus.HRESPM = 1'b1; bus.HREADYOUTM = 1'b0;
      #1;
      chk("err1_resp", {31'b0, bus.HRESPS},     32'd1);
      chk("err1_rdy",  {31'b0, bus.HREADYOUTS}, 32'd0);
      tick();
      drive(32'h5000_0004, 2'b01, 1'b1, 3'b000, 1'b0); bus.HREADYOUTM = 1'b1;
      #1;
      chk("err2_resp",  {31'b0, bus.HRESPS},     32'd1);
      chk("err2_rdy",   {31'b0, bus.HREADYOUTS}, 32'd1);
      chk("err2_req",   {31'b0, bus.req_port},   32'd0);
      chk("err2_trans", {30'b0, bus.HTRANSI},    32'd1);
      tick();
      idle_bus(); bus.HRESPM = 1'b0;
      #1;
      chk("busy_nocap_rdy",  {31'b0, bus.HREADYOUTS}, 32'd1);
      chk("busy_nocap_resp", {31'b0, bus.HRESPS},     32'd0);
      chk("busy_nocap_req",  {31'b0, bus.req_port},   32'd0);

      // 6: held SEQ INCR4 beat, then a reset pulse while it is held.
      drive(32'h8000_0004, 2'b11, 1'b0, 3'b011, 1'b0);
      tick();
      idle_bus();
      #1;
`ifdef INSTAGE_BURST_OVERRIDE_EN
      chk("seq_trans", {30'b0, bus.HTRANSI}, 32'd2);
      chk("seq_burst", {29'b0, bus.HBURSTI}, 32'd1);
`else
      chk("seq_trans", {30'b0, bus.HTRANSI}, 32'd3);
      chk("seq_burst", {29'b0, bus.HBURSTI}, 32'd3);
`endif
      chk("seq_addr", bus.HADDRI,              32'h8000_0004);
      chk("seq_rdy",  {31'b0, bus.HREADYOUTS}, 32'd0);
      HRESET = 1'b1;
      #1;
      chk("prst_req", {31'b0, bus.req_port},   32'd0);
      chk("prst_rdy", {31'b0, bus.HREADYOUTS}, 32'd1);
      tick();
      HRESET = 1'b0;
      #1;
      chk("post_rst_req",   {31'b0, bus.req_port},   32'd0);
      chk("post_rst_rdy",   {31'b0, bus.HREADYOUTS}, 32'd1);
      chk("post_rst_trans", {30'b0, bus.HTRANSI},    32'd0);
      tick();
      #1;
      chk("post_rst_idle", {31'b0, bus.HREADYOUTS}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
